// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg
//   Shared encodings for the instruction-fetch program-counter sequencer:
//   the decode-stage operation codes and the sequencer control states.
//   No ports; imported by pc_sequencer and return_addr_stack.
package pc_seq_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_SEQ    = 3'd0,
        OP_BRANCH = 3'd1,
        OP_JUMP   = 3'd2,
        OP_CALL   = 3'd3,
        OP_RET    = 3'd4,
        OP_HOLD   = 3'd5
    } op_e;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/pc_sequencer_ras.sv
// return_addr_stack
//   LIFO of return addresses held in circular storage with a top pointer.
//   When full, a push overwrites the oldest entry (the slot just past the
//   top wraps onto it), so the depth saturates instead of losing the
//   newest address.
// Ports:
//   clk, reset     clock and synchronous active-high reset (empties stack)
//   push, pop      one-cycle requests, never both at once
//   din            address pushed on push
//   top            current top entry (valid when depth > 0)
//   depth          number of occupied entries, registered
//   ovf, unf       combinational flags: push while full / pop while empty
module return_addr_stack
    import pc_seq_pkg::*;
#(
    parameter int ADDR_W    = 12,
    parameter int RAS_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  logic                           pop,
    input  logic [ADDR_W-1:0]              din,
    output logic [ADDR_W-1:0]              top,
    output logic [$clog2(RAS_DEPTH+1)-1:0] depth,
    output logic                           ovf,
    output logic                           unf
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int DEP_W = $clog2(RAS_DEPTH+1);

    logic [ADDR_W-1:0] mem [RAS_DEPTH];
    logic [PTR_W-1:0]  tp;
    logic [DEP_W-1:0]  cnt;
    logic              full;
    logic              empty;

    // Pointer arithmetic wraps at RAS_DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RAS_DEPTH-1)) ? '0 : p + PTR_W'(1);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
        return (p == '0) ? PTR_W'(RAS_DEPTH-1) : p - PTR_W'(1);
    endfunction

    assign full  = (cnt == DEP_W'(RAS_DEPTH));
    assign empty = (cnt == '0);
    assign ovf   = push & full;
    assign unf   = pop & empty;
    assign top   = mem[tp];
    assign depth = cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            tp  <= '0;
            cnt <= '0;
        end else if (push) begin
            tp <= ptr_inc(tp);
            if (!full)
                cnt <= cnt + DEP_W'(1);
        end else if (pop && !empty) begin
            tp  <= ptr_dec(tp);
            cnt <= cnt - DEP_W'(1);
        end
    end

    // Entry storage carries data only; emptiness is tracked by cnt alone.
    always_ff @(posedge clk) begin
        if (push)
            mem[ptr_inc(tp)] <= din;
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Program-counter sequencer for instruction fetch. Executes one decode op
//   per enabled edge: sequential step, relative branch, absolute jump,
//   call/return through return_addr_stack, and hold. After reset, one INIT
//   edge passes with pc at RESET_ADDR before pc_valid rises.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   en           advance enable; low freezes all state
//   op           operation code (see pc_seq_pkg::op_e; 6,7 are illegal)
//   target       jump/call address or signed branch offset
//   pc           registered program counter
//   pc_valid     high once the INIT edge has passed
//   ras_depth    occupied return-address entries
//   ras_ovf      pulse: CALL overwrote the oldest entry
//   ras_unf      pulse: RET found the stack empty
//   illegal_op   pulse: undefined op accepted
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int ADDR_W     = 12,
    parameter int STEP       = 1,
    parameter int RESET_ADDR = 0,
    parameter int RAS_DEPTH  = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           en,
    input  logic [OP_W-1:0]                op,
    input  logic [ADDR_W-1:0]              target,
    output logic [ADDR_W-1:0]              pc,
    output logic                           pc_valid,
    output logic [$clog2(RAS_DEPTH+1)-1:0] ras_depth,
    output logic                           ras_ovf,
    output logic                           ras_unf,
    output logic                           illegal_op
);

    localparam int                DEP_W   = $clog2(RAS_DEPTH+1);
    localparam logic [ADDR_W-1:0] STEP_V  = ADDR_W'(STEP);
    localparam logic [ADDR_W-1:0] RESET_V = ADDR_W'(RESET_ADDR);

    state_e            state;
    op_e               op_dec;
    logic              accept;
    logic              ras_push;
    logic              ras_pop;
    logic [ADDR_W-1:0] ras_top;
    logic              ras_ovf_c;
    logic              ras_unf_c;
    logic              illegal_c;
    logic [ADDR_W-1:0] pc_next;

    // Modulo-2^ADDR_W add of a signed offset; overflow wraps silently.
    function automatic logic [ADDR_W-1:0] wrap_add(
        input logic        [ADDR_W-1:0] base,
        input logic signed [ADDR_W-1:0] offs
    );
        logic signed [ADDR_W-1:0] sum;
        sum = signed'(base) + offs;
        return unsigned'(sum);
    endfunction

    assign op_dec = op_e'(op);
    // Ops only reach the stack on edges that actually execute them.
    assign accept = !reset && (state == ST_RUN) && en;

    always_comb begin
        pc_next   = pc;
        illegal_c = 1'b0;
        ras_push  = 1'b0;
        ras_pop   = 1'b0;
        case (op_dec)
            OP_SEQ:    pc_next = pc + STEP_V;
            OP_BRANCH: pc_next = wrap_add(pc, signed'(target));
            OP_JUMP:   pc_next = target;
            OP_CALL: begin
                pc_next  = target;
                ras_push = accept;
            end
            OP_RET: begin
                pc_next = (ras_depth == '0) ? RESET_V : ras_top;
                ras_pop = accept;
            end
            OP_HOLD:   pc_next = pc;
            default:   illegal_c = 1'b1;
        endcase
    end

    return_addr_stack #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .reset (reset),
        .push  (ras_push),
        .pop   (ras_pop),
        .din   (pc + STEP_V),
        .top   (ras_top),
        .depth (ras_depth),
        .ovf   (ras_ovf_c),
        .unf   (ras_unf_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_INIT;
            pc         <= RESET_V;
            pc_valid   <= 1'b0;
            ras_ovf    <= 1'b0;
            ras_unf    <= 1'b0;
            illegal_op <= 1'b0;
        end else begin
            ras_ovf    <= 1'b0;
            ras_unf    <= 1'b0;
            illegal_op <= 1'b0;
            case (state)
                ST_INIT: begin
                    pc_valid <= 1'b1;
                    state    <= ST_RUN;
                end
                ST_RUN: begin
                    if (en) begin
                        pc         <= pc_next;
                        ras_ovf    <= ras_ovf_c;
                        ras_unf    <= ras_unf_c;
                        illegal_op <= illegal_c;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
//   Scoreboard bench for pc_sequencer at default parameters. A driver
//   applies one op per cycle and pushes the behavioural model's expected
//   outputs; a monitor pops and compares them just after each rising edge.
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    localparam int ADDR_W = 12;
    localparam int DEPTH  = 4;
    localparam int DEP_W  = $clog2(DEPTH+1);
    localparam logic [ADDR_W-1:0] RA = '0;

    logic              clk = 1'b0;
    logic              reset;
    logic              en;
    logic [2:0]        op;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pc;
    logic              pc_valid;
    logic [DEP_W-1:0]  ras_depth;
    logic              ras_ovf;
    logic              ras_unf;
    logic              illegal_op;

    pc_sequencer #(
        .ADDR_W(ADDR_W), .STEP(1), .RESET_ADDR(0), .RAS_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .op(op), .target(target),
        .pc(pc), .pc_valid(pc_valid), .ras_depth(ras_depth),
        .ras_ovf(ras_ovf), .ras_unf(ras_unf), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                idx;
        logic [ADDR_W-1:0] pc;
        logic              valid;
        logic [DEP_W-1:0]  depth;
        logic              ovf;
        logic              unf;
        logic              ill;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_step  = 0;

    // behavioural model state
    logic [ADDR_W-1:0] m_pc;
    logic              m_valid;
    logic              m_init;
    logic [ADDR_W-1:0] m_ras[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic [2:0] o,
                        input logic [ADDR_W-1:0] t);
        exp_t x;
        @(negedge clk);
        reset = r; en = e; op = o; target = t;
        x.ovf = 1'b0; x.unf = 1'b0; x.ill = 1'b0;
        if (r) begin
            m_pc = RA; m_valid = 1'b0; m_init = 1'b1; m_ras.delete();
        end else if (m_init) begin
            m_valid = 1'b1; m_init = 1'b0;
        end else if (e) begin
            case (o)
                3'd0: m_pc = m_pc + 12'd1;
                3'd1: m_pc = m_pc + t;
                3'd2: m_pc = t;
                3'd3: begin
                    if (m_ras.size() == DEPTH) begin
                        void'(m_ras.pop_front());
                        x.ovf = 1'b1;
                    end
                    m_ras.push_back(m_pc + 12'd1);
                    m_pc = t;
                end
                3'd4: begin
                    if (m_ras.size() > 0) m_pc = m_ras.pop_back();
                    else begin m_pc = RA; x.unf = 1'b1; end
                end
                3'd5: ;
                default: x.ill = 1'b1;
            endcase
        end
        x.idx = n_step; x.pc = m_pc; x.valid = m_valid;
        x.depth = DEP_W'(m_ras.size());
        sb.push_back(x);
        n_step++;
    endtask

    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk($sformatf("pc@%0d", e.idx),       32'(pc),         32'(e.pc));
            chk($sformatf("valid@%0d", e.idx),    32'(pc_valid),   32'(e.valid));
            chk($sformatf("depth@%0d", e.idx),    32'(ras_depth),  32'(e.depth));
            chk($sformatf("ovf@%0d", e.idx),      32'(ras_ovf),    32'(e.ovf));
            chk($sformatf("unf@%0d", e.idx),      32'(ras_unf),    32'(e.unf));
            chk($sformatf("illegal@%0d", e.idx),  32'(illegal_op), 32'(e.ill));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; en = 1'b0; op = 3'd0; target = '0;
        m_pc = RA; m_valid = 1'b0; m_init = 1'b1;

        // reset, INIT, then sequential counting
        step(1, 0, 0, 0);
        step(1, 1, 2, 12'h123);
        step(0, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0);

        // wrap past the top of the address space, then branch back by 2
        step(0, 1, 2, 12'hFFE);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
        step(0, 1, 1, 12'hFFE);

        // nested call/return
        step(0, 1, 2, 12'h010);
        step(0, 1, 3, 12'h100);
        step(0, 1, 3, 12'h200);
        step(0, 1, 4, 0);
        step(0, 1, 4, 0);

        // stack overflow then underflow
        for (int i = 0; i < 5; i++) step(0, 1, 3, 12'h300 + 12'(i * 16));
        for (int i = 0; i < 5; i++) step(0, 1, 4, 0);
        step(0, 1, 4, 0);

        // call immediately followed by return
        step(0, 1, 2, 12'h444);
        step(0, 1, 3, 12'h800);
        step(0, 1, 4, 0);

        // stall with a pending jump, then illegal ops and hold
        for (int i = 0; i < 3; i++) step(0, 0, 2, 12'h555);
        step(0, 1, 7, 12'h555);
        step(0, 1, 0, 0);
        step(0, 1, 6, 12'h666);
        step(0, 1, 5, 12'h777);
        step(0, 0, 7, 0);

        // reset while the stack holds three entries
        for (int i = 0; i < 3; i++) step(0, 1, 3, 12'h900 + 12'(i));
        step(1, 1, 3, 12'hA00);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 4, 0);

        // randomized mix
        for (int i = 0; i < 400; i++) begin
            logic r, e;
            logic [2:0] o;
            r = ($urandom_range(0, 49) == 0);
            e = ($urandom_range(0, 4) != 0);
            o = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) o = ($urandom_range(0, 1) == 0) ? 3'd3 : 3'd4;
            step(r, e, o, 12'($urandom));
        end

        repeat (2) @(posedge clk);
        #2;
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the instruction-fetch stage. It extends the plain accumulate-by-offset counter with the following:
- configurable address width and step;
- absolute jumps;
- relative branches;
- call/return through an internal return-address stack (RAS);
- a hold mode;
- an explicit valid flag for the post-reset initialisation cycle.

It feeds the instruction-memory address port and takes its control from the decode stage.

## Interface

Parameters:
- ADDR_W, 12: PC and target width in bits.
- STEP, 1: increment applied by sequential ops; must be less than 2^ADDR_W.
- RESET_ADDR, 0: PC value loaded at reset; also the fallback target on RAS underflow.
- RAS_DEPTH, 4: number of return-address entries; must be at least 2.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- en  in  1  advance enable; when low, op is ignored and all state holds.
- op  in  3  operation code, sampled when en=1.
- target  in  ADDR_W  absolute address (JUMP, CALL) or two's-complement offset (BRANCH).
- pc  out  ADDR_W  current program counter, registered.
- pc_valid  out  1  high once the initialisation cycle has completed.
- ras_depth  out  $clog2(RAS_DEPTH+1)  number of occupied RAS entries.
- ras_ovf  out  1  one-cycle pulse when a CALL overwrites the oldest entry.
- ras_unf  out  1  one-cycle pulse when a RET finds the RAS empty.
- illegal_op  out  1  one-cycle pulse when an undefined op is accepted.

## Operation

Op encoding (op value: name, action):
- 0 SEQ: pc <= pc + STEP.
- 1 BRANCH: pc <= pc + target.
- 2 JUMP: pc <= target.
- 3 CALL: push pc + STEP; pc <= target.
- 4 RET: pc <= popped entry.
- 5 HOLD: pc unchanged.
- 6, 7: treated as HOLD, and illegal_op pulses.

Arithmetic and width rules:
- All PC arithmetic is modulo 2^ADDR_W; wrap-around is silent.
- BRANCH treats target as a signed offset, so target = all-ones moves the PC back by one.

Reset and initialisation (INIT / RUN states):
- reset=1: pc=RESET_ADDR, pc_valid=0, ras_depth=0, all pulse outputs 0. State goes to INIT.
- INIT: on the first edge with reset=0, pc_valid<=1 and the state goes to RUN. pc stays at RESET_ADDR and en/op are ignored on this edge.
- RUN: ops execute on every edge with en=1.

Return-address stack:
- LIFO.
- CALL with ras_depth<RAS_DEPTH: push; ras_depth increments.
- CALL with ras_depth=RAS_DEPTH: the oldest entry is discarded and the new entry pushed; ras_depth stays; ras_ovf pulses.
- RET with ras_depth>0: pc <= top entry; ras_depth decrements.
- RET with ras_depth=0: pc <= RESET_ADDR; ras_depth stays 0; ras_unf pulses.
- Any reset assertion, including mid-operation, empties the stack.

Pulse outputs:
- Asserted only on the cycle following the causing edge.
- Never asserted while en=0, reset=1, or in INIT.

## Timing

- Single-cycle latency: the effect of op sampled at edge N is visible on pc at edge N.
- Each edge accepts at most one op; there is no back-pressure.
- reset has priority over en and op.
- en=0 has priority over op.
- A CALL immediately followed by a RET returns to the pushed address. No bypass hazard exists because the RAS is written at the same edge pc updates.
- Outputs are registered, with no combinational path from inputs to outputs.

## Structure

- Package pc_seq_pkg:
  - op encoding as localparams/enum: OP_SEQ, OP_BRANCH, OP_JUMP, OP_CALL, OP_RET, OP_HOLD;
  - state encoding: ST_INIT, ST_RUN.
- Sub-module return_addr_stack, parametrised by ADDR_W and RAS_DEPTH:
  - inputs: push, pop, din;
  - outputs: top, depth, ovf, unf;
  - implemented as circular storage with a top pointer.
- pc_sequencer contains the state register, the next-PC mux and the pulse registers.

## Test plan

Defaults apply unless stated.

1. Reset, then en=1 with op=SEQ for 5 cycles:
   - first post-reset edge: pc=0 and pc_valid rises;
   - following edges: pc=1, 2, 3, 4.
2. Count past the top of the address space: from pc=0xFFE, apply SEQ ×3 → pc=0xFFF, 0x000, 0x001. Then BRANCH with target=0xFFE → pc=0xFFF.
3. Nested calls with RAS_DEPTH=4:
   - at pc=0x010, CALL 0x100; at 0x100, CALL 0x200;
   - RET → pc=0x101; RET → pc=0x011;
   - ras_depth sequence is 1, 2, 1, 0.
4. RAS boundaries: 5 consecutive CALLs → ras_ovf pulses on the 5th and ras_depth=4. Then 5 RETs → the 5th gives pc=RESET_ADDR and ras_unf pulses.
5. Stall and illegal op:
   - en=0 for 3 cycles with op=JUMP → pc unchanged and no pulses;
   - op=7 with en=1 → pc holds and illegal_op pulses for one cycle.
6. Reset mid-operation: assert reset with ras_depth=3 → next edge gives pc=RESET_ADDR, pc_valid=0, ras_depth=0; INIT repeats after release.
